// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU operation codes and the forwarding
// source selector used by the ID/EX operand stage.
package pipe_pkg;

  localparam int ALU_CTLW = 5;

  localparam logic [ALU_CTLW-1:0] ALU_AND = 5'd0;
  localparam logic [ALU_CTLW-1:0] ALU_OR  = 5'd1;
  localparam logic [ALU_CTLW-1:0] ALU_ADD = 5'd2;
  localparam logic [ALU_CTLW-1:0] ALU_SUB = 5'd6;
  localparam logic [ALU_CTLW-1:0] ALU_SLT = 5'd7;
  localparam logic [ALU_CTLW-1:0] ALU_NOR = 5'd12;
  localparam logic [ALU_CTLW-1:0] ALU_XOR = 5'd13;
  localparam logic [ALU_CTLW-1:0] ALU_SLL = 5'd16;
  localparam logic [ALU_CTLW-1:0] ALU_SRL = 5'd24;
  localparam logic [ALU_CTLW-1:0] ALU_SRA = 5'd25;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EXM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/fwd_mux_unit.sv
// Operand bypass for one source register. EX/MEM has priority over MEM/WB;
// register $0 is never bypassed.
module fwd_mux_unit
  import pipe_pkg::*;
#(
  parameter int DW  = 32,
  parameter int RAW = 5
) (
  input  logic [RAW-1:0] src_addr,
  input  logic [DW-1:0]  reg_data,
  input  logic           exm_reg_wr,
  input  logic [RAW-1:0] exm_dst,
  input  logic [DW-1:0]  exm_result,
  input  logic           wb_reg_wr,
  input  logic [RAW-1:0] wb_dst,
  input  logic [DW-1:0]  wb_data,
  output logic [DW-1:0]  fwd_data
);

  fwd_sel_t sel;

  // pick the youngest in-flight producer of this source
  always_comb begin
    sel = FWD_REG;
    if (exm_reg_wr && (src_addr != '0) && (exm_dst == src_addr)) begin
      sel = FWD_EXM;
    end else if (wb_reg_wr && (src_addr != '0) && (wb_dst == src_addr)) begin
      sel = FWD_WB;
    end
  end

  // operand mux driven by the selector
  always_comb begin
    case (sel)
      FWD_EXM: fwd_data = exm_result;
      FWD_WB:  fwd_data = wb_data;
      default: fwd_data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use
// hazard detection; feeds the ALU operands and controls.
// Build option: ID_EX_FORWARD_EN enables EX/MEM and MEM/WB bypass. Without
// it operands come from the register file only and any in-flight writer of
// an ID source (in EX or EX/MEM) stalls ID.
module id_ex_operand_stage
  import pipe_pkg::*;
#(
  parameter int DW   = 32,
  parameter int RAW  = 5,
  parameter int CTLW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [RAW-1:0]  id_rs_addr,
  input  logic [RAW-1:0]  id_rt_addr,
  input  logic [RAW-1:0]  id_dst_addr,
  input  logic [DW-1:0]   id_rs_data,
  input  logic [DW-1:0]   id_rt_data,
  input  logic [DW-1:0]   id_imm32,
  input  logic [4:0]      id_shamt,
  input  logic [CTLW-1:0] id_alu_ctl,
  input  logic            id_sign,
  input  logic            id_alusrc1,
  input  logic            id_alusrc2,
  input  logic            id_reg_wr,
  input  logic            id_mem_rd,
  input  logic            id_mem_wr,
  input  logic            id_mem2reg,
  input  logic            flush,
  input  logic            exm_reg_wr,
  input  logic [RAW-1:0]  exm_dst,
  input  logic [DW-1:0]   exm_result,
  input  logic            wb_reg_wr,
  input  logic [RAW-1:0]  wb_dst,
  input  logic [DW-1:0]   wb_data,
  output logic            stall_o,
  output logic            ex_valid,
  output logic [DW-1:0]   alu_in1,
  output logic [DW-1:0]   alu_in2,
  output logic [CTLW-1:0] alu_ctl,
  output logic            alu_sign,
  output logic [DW-1:0]   ex_store_data,
  output logic [RAW-1:0]  ex_dst,
  output logic            ex_reg_wr,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic            ex_mem2reg
);

  logic            valid_q,   valid_d;
  logic [RAW-1:0]  rs_addr_q, rs_addr_d;
  logic [RAW-1:0]  rt_addr_q, rt_addr_d;
  logic [RAW-1:0]  dst_q,     dst_d;
  logic [DW-1:0]   rs_data_q, rs_data_d;
  logic [DW-1:0]   rt_data_q, rt_data_d;
  logic [DW-1:0]   imm32_q,   imm32_d;
  logic [4:0]      shamt_q,   shamt_d;
  logic [CTLW-1:0] alu_ctl_q, alu_ctl_d;
  logic            sign_q,    sign_d;
  logic            alusrc1_q, alusrc1_d;
  logic            alusrc2_q, alusrc2_d;
  logic            reg_wr_q,  reg_wr_d;
  logic            mem_rd_q,  mem_rd_d;
  logic            mem_wr_q,  mem_wr_d;
  logic            mem2reg_q, mem2reg_d;

  logic            hit_rs, hit_rt;
  logic            stall_raw;
  logic            load_en;
  logic            exm_fwd_en, wb_fwd_en;
  logic [DW-1:0]   fwd_rs, fwd_rt;

`ifdef ID_EX_FORWARD_EN
  assign exm_fwd_en = exm_reg_wr;
  assign wb_fwd_en  = wb_reg_wr;
`else
  // Bypass is disabled by gating the writer enables into the mux units;
  // the register file writes through, so MEM/WB needs no attention.
  assign exm_fwd_en = 1'b0;
  assign wb_fwd_en  = 1'b0;
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{exm_result, wb_reg_wr, wb_dst, wb_data};
`endif

  // hazard detection against the instruction currently held in ID
  always_comb begin
    hit_rs = (dst_q != '0) && (dst_q == id_rs_addr);
    hit_rt = (dst_q != '0) && (dst_q == id_rt_addr);
`ifdef ID_EX_FORWARD_EN
    stall_raw = valid_q && mem_rd_q && id_valid && (hit_rs || hit_rt);
`else
    stall_raw = id_valid && (
                  (valid_q && reg_wr_q && (hit_rs || hit_rt)) ||
                  (exm_reg_wr && (exm_dst != '0) &&
                   ((exm_dst == id_rs_addr) || (exm_dst == id_rt_addr))));
`endif
    // a taken branch kills ID, so its hazard is moot
    stall_o = stall_raw && !flush && !reset;
    load_en = !flush && !stall_o;
  end

  // next-state: capture ID fields, or a zeroed bubble on flush/stall
  always_comb begin
    valid_d   = load_en ? id_valid    : 1'b0;
    rs_addr_d = load_en ? id_rs_addr  : '0;
    rt_addr_d = load_en ? id_rt_addr  : '0;
    dst_d     = load_en ? id_dst_addr : '0;
    rs_data_d = load_en ? id_rs_data  : '0;
    rt_data_d = load_en ? id_rt_data  : '0;
    imm32_d   = load_en ? id_imm32    : '0;
    shamt_d   = load_en ? id_shamt    : '0;
    alu_ctl_d = load_en ? id_alu_ctl  : '0;
    sign_d    = load_en ? id_sign     : 1'b0;
    alusrc1_d = load_en ? id_alusrc1  : 1'b0;
    alusrc2_d = load_en ? id_alusrc2  : 1'b0;
    reg_wr_d  = load_en ? id_reg_wr   : 1'b0;
    mem_rd_d  = load_en ? id_mem_rd   : 1'b0;
    mem_wr_d  = load_en ? id_mem_wr   : 1'b0;
    mem2reg_d = load_en ? id_mem2reg  : 1'b0;
  end

  // ID/EX pipeline register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      dst_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm32_q   <= '0;
      shamt_q   <= '0;
      alu_ctl_q <= '0;
      sign_q    <= 1'b0;
      alusrc1_q <= 1'b0;
      alusrc2_q <= 1'b0;
      reg_wr_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem2reg_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      dst_q     <= dst_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm32_q   <= imm32_d;
      shamt_q   <= shamt_d;
      alu_ctl_q <= alu_ctl_d;
      sign_q    <= sign_d;
      alusrc1_q <= alusrc1_d;
      alusrc2_q <= alusrc2_d;
      reg_wr_q  <= reg_wr_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      mem2reg_q <= mem2reg_d;
    end
  end

  fwd_mux_unit #(.DW(DW), .RAW(RAW)) u_fwd_rs (
    .src_addr   (rs_addr_q),
    .reg_data   (rs_data_q),
    .exm_reg_wr (exm_fwd_en),
    .exm_dst    (exm_dst),
    .exm_result (exm_result),
    .wb_reg_wr  (wb_fwd_en),
    .wb_dst     (wb_dst),
    .wb_data    (wb_data),
    .fwd_data   (fwd_rs)
  );

  fwd_mux_unit #(.DW(DW), .RAW(RAW)) u_fwd_rt (
    .src_addr   (rt_addr_q),
    .reg_data   (rt_data_q),
    .exm_reg_wr (exm_fwd_en),
    .exm_dst    (exm_dst),
    .exm_result (exm_result),
    .wb_reg_wr  (wb_fwd_en),
    .wb_dst     (wb_dst),
    .wb_data    (wb_data),
    .fwd_data   (fwd_rt)
  );

  // ALU operand selection after forwarding
  always_comb begin
    alu_in1       = alusrc1_q ? {{(DW-5){1'b0}}, shamt_q} : fwd_rs;
    alu_in2       = alusrc2_q ? imm32_q : fwd_rt;
    ex_store_data = fwd_rt;
  end

  assign ex_valid   = valid_q;
  assign alu_ctl    = alu_ctl_q;
  assign alu_sign   = sign_q;
  assign ex_dst     = dst_q;
  assign ex_reg_wr  = reg_wr_q;
  assign ex_mem_rd  = mem_rd_q;
  assign ex_mem_wr  = mem_wr_q;
  assign ex_mem2reg = mem2reg_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage; expectations follow the
// ID_EX_FORWARD_EN build setting.
module tb_id_ex_operand_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_dst_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm32;
  logic [4:0]  id_shamt;
  logic [4:0]  id_alu_ctl;
  logic        id_sign, id_alusrc1, id_alusrc2;
  logic        id_reg_wr, id_mem_rd, id_mem_wr, id_mem2reg;
  logic        flush;
  logic        exm_reg_wr;
  logic [4:0]  exm_dst;
  logic [31:0] exm_result;
  logic        wb_reg_wr;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        stall_o, ex_valid;
  logic [31:0] alu_in1, alu_in2, ex_store_data;
  logic [4:0]  alu_ctl, ex_dst;
  logic        alu_sign, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_mem2reg;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DW(32), .RAW(5), .CTLW(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_dst_addr(id_dst_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm32(id_imm32),
    .id_shamt(id_shamt), .id_alu_ctl(id_alu_ctl), .id_sign(id_sign),
    .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2), .id_reg_wr(id_reg_wr),
    .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_mem2reg(id_mem2reg),
    .flush(flush), .exm_reg_wr(exm_reg_wr), .exm_dst(exm_dst),
    .exm_result(exm_result), .wb_reg_wr(wb_reg_wr), .wb_dst(wb_dst),
    .wb_data(wb_data), .stall_o(stall_o), .ex_valid(ex_valid),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctl(alu_ctl),
    .alu_sign(alu_sign), .ex_store_data(ex_store_data), .ex_dst(ex_dst),
    .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_mem2reg(ex_mem2reg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clr_id();
    id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_dst_addr = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm32 = 0; id_shamt = 0;
    id_alu_ctl = 0; id_sign = 0; id_alusrc1 = 0; id_alusrc2 = 0;
    id_reg_wr = 0; id_mem_rd = 0; id_mem_wr = 0; id_mem2reg = 0;
  endtask

  task automatic clr_fwd();
    exm_reg_wr = 0; exm_dst = 0; exm_result = 0;
    wb_reg_wr = 0; wb_dst = 0; wb_data = 0;
  endtask

  // R-type style instruction in ID
  task automatic set_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [4:0] ctl);
    clr_id();
    id_valid = 1; id_rs_addr = rs; id_rt_addr = rt; id_dst_addr = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_alu_ctl = ctl; id_reg_wr = 1;
  endtask

  // lw rt, imm(rs)
  task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rsd, input logic [31:0] imm);
    clr_id();
    id_valid = 1; id_rs_addr = rs; id_rt_addr = rt; id_dst_addr = rt;
    id_rs_data = rsd; id_imm32 = imm; id_alusrc2 = 1; id_alu_ctl = ALU_ADD;
    id_reg_wr = 1; id_mem_rd = 1; id_mem2reg = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_id();
    clr_fwd();
    flush = 0;
    reset = 1;
    set_r(5'd1, 5'd2, 5'd3, 32'h1234, 32'h5678, ALU_ADD);
    tick();
    tick();
    #1;
    chk("rst_valid", ex_valid, 0);
    chk("rst_in1", alu_in1, 0);
    chk("rst_in2", alu_in2, 0);
    chk("rst_ctl", alu_ctl, 0);
    chk("rst_dst", ex_dst, 0);
    chk("rst_regwr", ex_reg_wr, 0);
    chk("rst_stall", stall_o, 0);
    reset = 0;

    // add $3,$1,$2 followed by sub $4,$3,$1
    set_r(5'd1, 5'd2, 5'd3, 32'h5, 32'h7, ALU_ADD);
    tick();
    set_r(5'd3, 5'd1, 5'd4, 32'h99, 32'h5, ALU_SUB);
    #1;
    chk("add_valid", ex_valid, 1);
    chk("add_in1", alu_in1, 32'h5);
    chk("add_in2", alu_in2, 32'h7);
    chk("add_ctl", alu_ctl, ALU_ADD);
    chk("add_dst", ex_dst, 3);
`ifdef ID_EX_FORWARD_EN
    chk("sub_nostall", stall_o, 0);
    tick();
    exm_reg_wr = 1; exm_dst = 3; exm_result = 32'h10;
    #1;
    chk("sub_fwd_exm", alu_in1, 32'h10);
    chk("sub_in2", alu_in2, 32'h5);
    chk("sub_ctl", alu_ctl, ALU_SUB);
`else
    chk("sub_stall_ex", stall_o, 1);
    tick();
    exm_reg_wr = 1; exm_dst = 3; exm_result = 32'h10;
    #1;
    chk("sub_bubble1", ex_valid, 0);
    chk("sub_stall_exm", stall_o, 1);
    tick();
    clr_fwd();
    wb_reg_wr = 1; wb_dst = 3; wb_data = 32'h10;
    id_rs_data = 32'h10;
    #1;
    chk("sub_release", stall_o, 0);
    tick();
    #1;
    chk("sub_in1", alu_in1, 32'h10);
    chk("sub_ctl", alu_ctl, ALU_SUB);
`endif
    clr_fwd();

    // both EX/MEM and MEM/WB target $5
    set_r(5'd5, 5'd5, 5'd9, 32'h55, 32'h66, ALU_ADD);
    id_alusrc2 = 1; id_imm32 = 32'h1234;
    tick();
    clr_id();
    exm_reg_wr = 1; exm_dst = 5; exm_result = 32'hA;
    wb_reg_wr = 1; wb_dst = 5; wb_data = 32'hB;
    #1;
    chk("dual_in2_imm", alu_in2, 32'h1234);
`ifdef ID_EX_FORWARD_EN
    chk("dual_exm_wins", alu_in1, 32'hA);
    chk("dual_store", ex_store_data, 32'hA);
    exm_reg_wr = 0;
    #1;
    chk("wb_only_in1", alu_in1, 32'hB);
    chk("wb_only_store", ex_store_data, 32'hB);
`else
    chk("nofwd_in1", alu_in1, 32'h55);
    chk("nofwd_store", ex_store_data, 32'h66);
`endif
    clr_fwd();

    // lw $6 then add $7,$6,$6
    set_lw(5'd1, 5'd6, 32'h100, 32'h4);
    tick();
    set_r(5'd6, 5'd6, 5'd7, 32'h77, 32'h77, ALU_ADD);
    #1;
    chk("lw_memrd", ex_mem_rd, 1);
    chk("lw_mem2reg", ex_mem2reg, 1);
    chk("lw_in1", alu_in1, 32'h100);
    chk("lw_in2", alu_in2, 32'h4);
    chk("lu_stall", stall_o, 1);
    tick();
    exm_reg_wr = 1; exm_dst = 6; exm_result = 32'h104;
    #1;
    chk("lu_bubble", ex_valid, 0);
    chk("lu_bubble_memrd", ex_mem_rd, 0);
`ifdef ID_EX_FORWARD_EN
    chk("lu_one_cycle", stall_o, 0);
    tick();
    clr_fwd();
    wb_reg_wr = 1; wb_dst = 6; wb_data = 32'hDEAD;
    #1;
`else
    chk("lu_stall_exm", stall_o, 1);
    tick();
    clr_fwd();
    wb_reg_wr = 1; wb_dst = 6; wb_data = 32'hDEAD;
    id_rs_data = 32'hDEAD; id_rt_data = 32'hDEAD;
    #1;
    chk("lu_release", stall_o, 0);
    tick();
    #1;
`endif
    chk("lu_valid", ex_valid, 1);
    chk("lu_dst", ex_dst, 7);
    chk("lu_in1", alu_in1, 32'hDEAD);
    chk("lu_in2", alu_in2, 32'hDEAD);
    clr_id();
    clr_fwd();

    // load-use coinciding with flush
    set_lw(5'd1, 5'd8, 32'h200, 32'h0);
    tick();
    set_r(5'd8, 5'd2, 5'd9, 32'h1, 32'h2, ALU_OR);
    #1;
    chk("fl_stall_pre", stall_o, 1);
    flush = 1;
    #1;
    chk("fl_stall_killed", stall_o, 0);
    tick();
    flush = 0;
    clr_id();
    #1;
    chk("fl_valid", ex_valid, 0);
    chk("fl_regwr", ex_reg_wr, 0);
    chk("fl_in1", alu_in1, 0);

    // register $0 never stalls nor forwards
    set_lw(5'd1, 5'd0, 32'h300, 32'h0);
    tick();
    set_r(5'd0, 5'd0, 5'd10, 32'h0, 32'h0, ALU_ADD);
    #1;
    chk("z_nostall", stall_o, 0);
    tick();
    exm_reg_wr = 1; exm_dst = 0; exm_result = 32'hFFFF;
    wb_reg_wr = 1; wb_dst = 0; wb_data = 32'hBEEF;
    #1;
    chk("z_in1", alu_in1, 0);
    chk("z_in2", alu_in2, 0);
    chk("z_nostall2", stall_o, 0);
    clr_fwd();

    // shift with shamt operand and sign bit
    set_r(5'd0, 5'd2, 5'd11, 32'h0, 32'h3, ALU_SLL);
    id_alusrc1 = 1; id_shamt = 5'd5; id_sign = 1;
    tick();
    clr_id();
    #1;
    chk("sll_in1", alu_in1, 32'h5);
    chk("sll_in2", alu_in2, 32'h3);
    chk("sll_ctl", alu_ctl, ALU_SLL);
    chk("sll_sign", alu_sign, 1);

    // reset mid-stream
    reset = 1;
    tick();
    #1;
    chk("rst2_valid", ex_valid, 0);
    chk("rst2_ctl", alu_ctl, 0);
    chk("rst2_sign", alu_sign, 0);
    reset = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
